// File: rtl/sump_status_pkg.sv
// Shared encoding for the sump monitor. The state codes double as the
// message-select code that the VGA text-overlay stage decodes.
package sump_status_pkg;

  typedef enum logic [1:0] {
    ST_DRY    = 2'b00,
    ST_WET_LO = 2'b01,
    ST_WET_HI = 2'b10,
    ST_FAULT  = 2'b11
  } state_t;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a stability counter. The debounced
// output only changes after the synchronised input has disagreed with it
// for DEB_CYCLES consecutive cycles.
module sync_debounce #(
  parameter int DEB_CYCLES = 250000,
  parameter int DEB_W      = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic db
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [DEB_W-1:0] cnt;

  // Synchronise the raw input, then count how long it disagrees with db.
  // NOTE: every flop here uses <= so all of them sample the pre-edge values;
  // blocking assignments would collapse the two synchroniser stages into one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      db    <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= ~db;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sump_status_encoder.sv
// Sump monitor front end: conditions the float/pump/ack inputs, runs the
// flood-state FSM with frame-counted hysteresis and publishes a status code
// that only changes on the VS falling edge.
module sump_status_encoder
  import sump_status_pkg::*;
#(
  parameter int DEB_CYCLES        = 250000,
  parameter int DEB_W             = 18,
  parameter int HOLD_FRAMES       = 60,
  parameter int FB_TIMEOUT_FRAMES = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vs,
  input  logic       water_lo,
  input  logic       water_hi,
  input  logic       pump_fb,
  input  logic       ack,
  output logic [1:0] status,
  output logic       status_chg,
  output logic       pump_on,
  output logic       alarm
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam int FB_W   = $clog2(FB_TIMEOUT_FRAMES + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_FRAMES);
  localparam logic [FB_W-1:0]   FB_LAST   = FB_W'(FB_TIMEOUT_FRAMES - 1);
  localparam logic [FB_W-1:0]   FB_MAX    = FB_W'(FB_TIMEOUT_FRAMES);

  logic lo_db, hi_db, fb_db, ack_db;
  logic ack_db_q;
  logic vs_q;
  logic frame_tick;
  logic ack_pulse;
  logic incons;
  logic hold_cond;
  logic hold_fire;
  logic fb_fire;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [FB_W-1:0]   fb_cnt;

  sync_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_lo (
    .clk(clk), .reset(reset), .din(water_lo), .db(lo_db)
  );
  sync_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_hi (
    .clk(clk), .reset(reset), .din(water_hi), .db(hi_db)
  );
  sync_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_fb (
    .clk(clk), .reset(reset), .din(pump_fb), .db(fb_db)
  );
  sync_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_ack (
    .clk(clk), .reset(reset), .din(ack), .db(ack_db)
  );

  assign frame_tick = vs_q & ~vs;
  assign ack_pulse  = ack_db & ~ack_db_q;
  assign incons     = hi_db & ~lo_db;

  // Exit condition that the hysteresis counter is timing in the current state.
  // NOTE: the default assignment first keeps this purely combinational; a
  // path that left hold_cond unassigned would infer a latch.
  always_comb begin
    hold_cond = 1'b0;
    case (state)
      ST_WET_LO: hold_cond = ~lo_db;
      ST_WET_HI: hold_cond = ~hi_db;
      default:   hold_cond = 1'b0;
    endcase
  end

  assign hold_fire = frame_tick & hold_cond & (hold_cnt == HOLD_LAST);
  assign fb_fire   = frame_tick & (state == ST_WET_HI) & ~fb_db & (fb_cnt == FB_LAST);

  // Edge detectors for VS and the debounced acknowledge button.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_q     <= 1'b1;
      ack_db_q <= 1'b0;
    end else begin
      vs_q     <= vs;
      ack_db_q <= ack_db;
    end
  end

  // Flood-state FSM with hysteresis counters; any transition clears both counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_DRY;
      hold_cnt <= '0;
      fb_cnt   <= '0;
    end else begin
      if (!hold_cond) begin
        hold_cnt <= '0;
      end else if (frame_tick && hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + 1'b1;
      end

      if (state != ST_WET_HI || fb_db) begin
        fb_cnt <= '0;
      end else if (frame_tick && fb_cnt != FB_MAX) begin
        fb_cnt <= fb_cnt + 1'b1;
      end

      case (state)
        ST_DRY: begin
          if (incons) begin
            state <= ST_FAULT;  hold_cnt <= '0; fb_cnt <= '0;
          end else if (lo_db) begin
            state <= ST_WET_LO; hold_cnt <= '0; fb_cnt <= '0;
          end
        end
        ST_WET_LO: begin
          if (incons) begin
            state <= ST_FAULT;  hold_cnt <= '0; fb_cnt <= '0;
          end else if (hi_db) begin
            state <= ST_WET_HI; hold_cnt <= '0; fb_cnt <= '0;
          end else if (hold_fire) begin
            state <= ST_DRY;    hold_cnt <= '0; fb_cnt <= '0;
          end
        end
        ST_WET_HI: begin
          if (incons || fb_fire) begin
            state <= ST_FAULT;  hold_cnt <= '0; fb_cnt <= '0;
          end else if (hold_fire) begin
            state <= ST_WET_LO; hold_cnt <= '0; fb_cnt <= '0;
          end
        end
        ST_FAULT: begin
          if (ack_pulse && !incons) begin
            state <= ST_DRY;    hold_cnt <= '0; fb_cnt <= '0;
          end
        end
        default: begin
          state <= ST_DRY;      hold_cnt <= '0; fb_cnt <= '0;
        end
      endcase
    end
  end

  // Registered outputs: pump/alarm follow the FSM, status is frame-aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status     <= ST_DRY;
      status_chg <= 1'b0;
      pump_on    <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      pump_on    <= (state == ST_WET_HI);
      alarm      <= (state == ST_WET_HI) || (state == ST_FAULT);
      status_chg <= 1'b0;
      if (frame_tick) begin
        status     <= state;
        status_chg <= (state != status);
      end
    end
  end

endmodule

// File: tb/tb_sump_status_encoder.sv
// Directed bench for sump_status_encoder with short debounce and hysteresis
// settings; VS is low for 2 cycles out of every 100.
module tb_sump_status_encoder;
  import sump_status_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       vs;
  logic       water_lo;
  logic       water_hi;
  logic       pump_fb;
  logic       ack;
  logic [1:0] status;
  logic       status_chg;
  logic       pump_on;
  logic       alarm;

  int total     = 0;
  int bad       = 0;
  int cyc       = 0;
  int chg_count = 0;
  bit vs_auto   = 1'b0;
  bit prev_vs   = 1'b1;
  bit tick_edge = 1'b0;

  sump_status_encoder #(
    .DEB_CYCLES(4),
    .DEB_W(3),
    .HOLD_FRAMES(3),
    .FB_TIMEOUT_FRAMES(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vs(vs),
    .water_lo(water_lo),
    .water_hi(water_hi),
    .pump_fb(pump_fb),
    .ack(ack),
    .status(status),
    .status_chg(status_chg),
    .pump_on(pump_on),
    .alarm(alarm)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: drive vs for the coming edge, then sample 1 time unit after it.
  task automatic clk1();
    if (vs_auto) vs = ((cyc % 100) < 98);
    tick_edge = prev_vs && !vs;
    @(posedge clk);
    #1;
    cyc++;
    prev_vs = vs;
    if (status_chg) chg_count++;
  endtask

  task automatic run(input int n);
    repeat (n) clk1();
  endtask

  // Advance until just after the edge on which a frame tick was applied.
  task automatic next_frame(input string tag);
    int k;
    k = 0;
    do begin
      clk1();
      k++;
    end while (!tick_edge && k < 250);
    check({tag, "_tick_seen"}, 8'(tick_edge), 8'd1);
  endtask

  initial begin
    reset = 1'b0; vs = 1'b1;
    water_lo = 1'b0; water_hi = 1'b0; pump_fb = 1'b0; ack = 1'b0;

    // Reset values.
    #1;
    check("rst_status", 8'(status), 8'h0);
    check("rst_chg", 8'(status_chg), 8'h0);
    check("rst_pump", 8'(pump_on), 8'h0);
    check("rst_alarm", 8'(alarm), 8'h0);
    run(3);
    reset = 1'b1;
    cyc = 0;
    vs_auto = 1'b1;
    clk1();
    check("rel_status", 8'(status), 8'h0);
    check("rel_chg", 8'(status_chg), 8'h0);
    next_frame("f0");
    check("f0_status", 8'(status), 8'h0);
    check("f0_chg", 8'(status_chg), 8'h0);

    // DRY -> WET_LO: 2 sync + 4 debounce + 1 FSM cycle.
    water_lo = 1'b1;
    run(6);
    check("lo_state6", 8'(dut.state), 8'(ST_DRY));
    run(1);
    check("lo_state7", 8'(dut.state), 8'(ST_WET_LO));
    check("lo_status_early", 8'(status), 8'h0);
    next_frame("lo");
    check("lo_status", 8'(status), 8'h1);
    check("lo_chg", 8'(status_chg), 8'h1);
    clk1();
    check("lo_chg_off", 8'(status_chg), 8'h0);

    // WET_LO -> WET_HI with pump feedback present.
    water_hi = 1'b1; pump_fb = 1'b1;
    run(8);
    check("hi_state", 8'(dut.state), 8'(ST_WET_HI));
    check("hi_pump", 8'(pump_on), 8'h1);
    check("hi_alarm", 8'(alarm), 8'h1);
    next_frame("hi");
    check("hi_status", 8'(status), 8'h2);
    check("hi_chg", 8'(status_chg), 8'h1);

    // Bounce: water_hi low for 2 ticks then back; hold count must clear.
    water_hi = 1'b0;
    next_frame("b1");
    check("b1_state", 8'(dut.state), 8'(ST_WET_HI));
    next_frame("b2");
    check("b2_state", 8'(dut.state), 8'(ST_WET_HI));
    water_hi = 1'b1;
    next_frame("b3");
    next_frame("b4");
    next_frame("b5");
    check("b5_state", 8'(dut.state), 8'(ST_WET_HI));
    check("b5_status", 8'(status), 8'h2);

    // Real exit: transition on the 3rd tick, status shows it on the 4th.
    water_hi = 1'b0;
    next_frame("x1");
    check("x1_state", 8'(dut.state), 8'(ST_WET_HI));
    next_frame("x2");
    check("x2_state", 8'(dut.state), 8'(ST_WET_HI));
    check("x2_status", 8'(status), 8'h2);
    next_frame("x3");
    check("x3_state", 8'(dut.state), 8'(ST_WET_LO));
    check("x3_status", 8'(status), 8'h2);
    check("x3_chg", 8'(status_chg), 8'h0);
    next_frame("x4");
    check("x4_status", 8'(status), 8'h1);
    check("x4_chg", 8'(status_chg), 8'h1);
    check("x4_pump", 8'(pump_on), 8'h0);
    check("x4_alarm", 8'(alarm), 8'h0);

    // Pump feedback lost in WET_HI: FAULT on the 5th tick.
    water_hi = 1'b1; pump_fb = 1'b0;
    run(10);
    check("fb_state", 8'(dut.state), 8'(ST_WET_HI));
    next_frame("t1");
    check("t1_status", 8'(status), 8'h2);
    next_frame("t2");
    next_frame("t3");
    next_frame("t4");
    check("t4_state", 8'(dut.state), 8'(ST_WET_HI));
    next_frame("t5");
    check("t5_state", 8'(dut.state), 8'(ST_FAULT));
    check("t5_status", 8'(status), 8'h2);
    clk1();
    check("t5_alarm", 8'(alarm), 8'h1);
    check("t5_pump", 8'(pump_on), 8'h0);
    next_frame("t6");
    check("t6_status", 8'(status), 8'h3);
    check("t6_chg", 8'(status_chg), 8'h1);

    // Ack ignored while inconsistent, accepted once the sensors agree.
    water_lo = 1'b0;
    run(10);
    ack = 1'b1; run(10);
    ack = 1'b0; run(10);
    check("ack1_state", 8'(dut.state), 8'(ST_FAULT));
    check("ack1_status", 8'(status), 8'h3);
    water_hi = 1'b0;
    run(10);
    ack = 1'b1; run(10);
    check("ack2_state", 8'(dut.state), 8'(ST_DRY));
    check("ack2_alarm", 8'(alarm), 8'h0);
    ack = 1'b0; run(10);
    check("ack2_status_hold", 8'(status), 8'h3);
    next_frame("ack2");
    check("ack2_status", 8'(status), 8'h0);
    check("ack2_chg", 8'(status_chg), 8'h1);

    // Asynchronous reset in the middle of WET_HI.
    water_lo = 1'b1; water_hi = 1'b1; pump_fb = 1'b1;
    run(10);
    check("pre_rst_state", 8'(dut.state), 8'(ST_WET_HI));
    next_frame("pre_rst");
    check("pre_rst_status", 8'(status), 8'h2);
    run(5);
    vs_auto = 1'b0; vs = 1'b1;
    reset = 1'b0;
    #1;
    check("mid_rst_status", 8'(status), 8'h0);
    check("mid_rst_pump", 8'(pump_on), 8'h0);
    check("mid_rst_alarm", 8'(alarm), 8'h0);
    water_lo = 1'b0; water_hi = 1'b0; pump_fb = 1'b0;
    run(2);
    reset = 1'b1;
    water_lo = 1'b1;
    run(10);
    check("post_rst_state", 8'(dut.state), 8'(ST_WET_LO));
    check("post_rst_status", 8'(status), 8'h0);
    chg_count = 0;
    vs = 1'b0; run(3);
    vs = 1'b1; run(5);
    check("vs3_updates", 8'(chg_count), 8'd1);
    check("vs3_status", 8'(status), 8'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
